// File: rtl/seqdiv32_pkg.sv
// Shared definitions for the seqdiv32 divider: state encoding and constants.
package seqdiv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [4:0]  ITER_LAST     = 5'd31;

endpackage

// File: rtl/seqdiv32_addsub32.sv
// addsub32: 32-bit adder/subtractor; sub=1 computes a-b with cout=1 when a>=b (no borrow).
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] full;

    // Subtraction is a + ~b + 1, so the carry out doubles as "no borrow"
    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
        sum  = full[31:0];
        cout = full[32];
    end

endmodule

// File: rtl/seqdiv32.sv
// seqdiv32: sequential 32-bit restoring divider, one quotient bit per cycle.
// Define SEQDIV32_SIGNED_EN for two's-complement operands (adds the FIX state).
module seqdiv32
    import seqdiv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    div_state_t  state;
    div_state_t  state_next;

    logic [31:0] r;
    logic [31:0] q;
    logic [31:0] d;
    logic [4:0]  count;

    logic [32:0] t;
    logic [31:0] diff;
    logic        cout;
    logic        accept;
    logic [31:0] r_step;
    logic [31:0] q_step;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;

`ifdef SEQDIV32_SIGNED_EN
    logic        neg_q;
    logic        neg_r;
`endif

    // Shift the next dividend bit into the partial remainder for the trial subtraction
    assign t = {r, q[31]};

    addsub32 u_addsub (
        .a    (t[31:0]),
        .b    (d),
        .sub  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    // Keep the difference when the shifted remainder (including its 33rd bit) covers the divisor
    always_comb begin
        accept = t[32] | cout;
        r_step = accept ? diff : t[31:0];
        q_step = {q[30:0], accept};
    end

    // Operand magnitudes at load; unsigned build passes operands straight through
    always_comb begin
`ifdef SEQDIV32_SIGNED_EN
        dividend_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
        divisor_mag  = divisor[31]  ? (~divisor  + 32'd1) : divisor;
`else
        dividend_mag = dividend;
        divisor_mag  = divisor;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = (divisor == 32'd0) ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                busy = 1'b1;
                if (count == 5'd0) begin
`ifdef SEQDIV32_SIGNED_EN
                    state_next = ST_FIX;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef SEQDIV32_SIGNED_EN
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand load, iteration step, result capture and sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= 32'd0;
            q           <= 32'd0;
            d           <= 32'd0;
            count       <= 5'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
`ifdef SEQDIV32_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r     <= 32'd0;
                            q     <= dividend_mag;
                            d     <= divisor_mag;
                            count <= ITER_LAST;
`ifdef SEQDIV32_SIGNED_EN
                            neg_q <= dividend[31] ^ divisor[31];
                            neg_r <= dividend[31];
`endif
                        end
                    end
                end
                ST_ITER: begin
                    r     <= r_step;
                    q     <= q_step;
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        quotient    <= q_step;
                        remainder   <= r_step;
                        div_by_zero <= 1'b0;
                    end
                end
`ifdef SEQDIV32_SIGNED_EN
                ST_FIX: begin
                    if (neg_q) quotient  <= ~quotient + 32'd1;
                    if (neg_r) remainder <= ~remainder + 32'd1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqdiv32.sv
// tb_seqdiv32: directed self-checking bench for seqdiv32 (either build of SEQDIV32_SIGNED_EN).
module tb_seqdiv32;

`ifdef SEQDIV32_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seqdiv32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division and wait for done; cyc is the cycle done was seen (1 = right after accept), -1 on timeout
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(posedge clk); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = -1;
        for (int n = 1; n <= 100; n++) begin
            if (done) begin
                cyc = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Outputs while reset is held
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        #12;
        checks++;
        if ({ready, busy, done, div_by_zero} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got rdy/busy/done/dbz=%b need 1000", {ready, busy, done, div_by_zero});
        end
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_results got q=%h r=%h need 0/0", quotient, remainder);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Plain unsigned divisions including the extremes
    task automatic test_unsigned();
        int cyc;
        run_div(32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL u100_7_latency got %0d need %0d", cyc, LAT);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_result got q=%0d r=%0d dbz=%b need 14/2/0", quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_after got ready=%b done=%b need 1/0", ready, done);
        end
        run_div(32'hFFFF_FFFF, 32'd1, cyc);
        checks++;
        if (cyc !== LAT || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            errors++;
            $display("FAIL max_by_1 got cyc=%0d q=%h r=%h need %0d/ffffffff/0", cyc, quotient, remainder, LAT);
        end
        run_div(32'd7, 32'd9, cyc);
        checks++;
        if (cyc !== LAT || quotient !== 32'd0 || remainder !== 32'd7) begin
            errors++;
            $display("FAIL u7_9 got cyc=%0d q=%0d r=%0d need %0d/0/7", cyc, quotient, remainder, LAT);
        end
    endtask

    // Divide by zero finishes in one cycle and holds its flag
    task automatic test_div_by_zero();
        int cyc;
        run_div(32'd5, 32'd0, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL dbz_latency got %0d need 1", cyc);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%0d dbz=%b need ffffffff/5/1", quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold got q=%h r=%0d dbz=%b rdy=%b need ffffffff/5/1/1", quotient, remainder, div_by_zero, ready);
        end
    endtask

    // start pulses while busy or in the done cycle must be dropped
    task automatic test_ignore_start();
        int cyc;
        int extra_done;
        logic ready_seen;
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = -1;
        ready_seen = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (done) begin
                cyc = n;
                break;
            end
            if (ready) ready_seen = 1'b1;
            start = (n == 5 || n == 33);
            if (start) begin
                dividend = 32'd50;
                divisor  = 32'd3;
            end
            @(posedge clk); #1;
        end
        // Pulse again during the done cycle itself
        if (ready) ready_seen = 1'b1;
        start = 1'b1; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (cyc !== LAT || ready_seen !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run got cyc=%0d ready_seen=%b need %0d/0", cyc, ready_seen, LAT);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL ignore_result got q=%0d r=%0d need 14/2", quotient, remainder);
        end
        extra_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) extra_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra_done !== 0 || ready !== 1'b1 || quotient !== 32'd14) begin
            errors++;
            $display("FAIL ignore_no_queue got extra_done=%0d ready=%b q=%0d need 0/1/14", extra_done, ready, quotient);
        end
    endtask

    // Reset in the middle of a divide aborts it; a fresh divide then works
    task automatic test_abort_reset();
        int cyc;
        int extra_done;
        @(posedge clk); #1;
        dividend = 32'd200; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, div_by_zero} !== 4'b1000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs got rdy/busy/done/dbz=%b q=%h r=%h need 1000/0/0",
                     {ready, busy, done, div_by_zero}, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) extra_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra_done !== 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_done got extra_done=%0d ready=%b need 0/1", extra_done, ready);
        end
        run_div(32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== LAT || quotient !== 32'd14 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL abort_recover got cyc=%0d q=%0d r=%0d need %0d/14/2", cyc, quotient, remainder, LAT);
        end
    endtask

`ifdef SEQDIV32_SIGNED_EN
    // Two's-complement operands and the most-negative corner
    task automatic test_signed();
        int cyc;
        run_div(32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 34 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL s_m7_2 got cyc=%0d q=%h r=%h need 34/fffffffd/ffffffff", cyc, quotient, remainder);
        end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL s_min_m1 got q=%h r=%h need 80000000/0", quotient, remainder);
        end
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        $display("[TB] seqdiv32 bench start, expected latency %0d", LAT);
        test_reset();
        test_unsigned();
        test_div_by_zero();
        test_ignore_start();
        test_abort_reset();
`ifdef SEQDIV32_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
